// File: rtl/dmem_responder_if.sv
// CPU load/store port bundle between the CPU (master) and the data-memory responder (slave).
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface dmem_responder_if #(
  parameter int W = `WORD_WIDTH
);
  logic         load_en;
  logic [W-1:0] l_addr;
  logic [W-1:0] l_data;
  logic         store_en;
  logic [W-1:0] s_addr;
  logic [W-1:0] s_data;
  logic         stall;
  logic         misalign;

  modport master (
    output load_en, l_addr, store_en, s_addr, s_data,
    input  l_data, stall, misalign
  );

  modport slave (
    input  load_en, l_addr, store_en, s_addr, s_data,
    output l_data, stall, misalign
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM with single-cycle stores and LAT-cycle loads signalled on stall.
// Optional alignment checking is compiled in with `define DMEM_ALIGN_CHECK_EN.
//
// state  | meaning
// S_IDLE | accepting requests; stores commit here, loads are latched here
// S_WAIT | load in flight, stall high, counting down to the RAM capture
// S_RESP | captured word on l_data, stall low, always returns to S_IDLE
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module dmem_responder #(
  parameter int W          = `WORD_WIDTH,
  parameter int DEPTH_LOG2 = 10,
  parameter int LAT        = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  if (LAT < 0 || LAT > 15) begin : g_bad_lat
    $error("dmem_responder: LAT must be within 0..15");
  end
  if (DEPTH_LOG2 + 2 > W) begin : g_bad_depth
    $error("dmem_responder: DEPTH_LOG2+2 must not exceed W");
  end

  localparam bit         HAS_LAT  = (LAT != 0);
  localparam int         LAT_M1   = (LAT > 0) ? LAT - 1 : 0;
  localparam logic [3:0] CNT_INIT = LAT_M1[3:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [W-1:0]          r_l_data;
  logic [W-1:0]          r_mem [0:(1<<DEPTH_LOG2)-1];

  logic [DEPTH_LOG2-1:0] w_l_idx;
  logic [DEPTH_LOG2-1:0] w_s_idx;
  logic                  w_idle;
  logic                  w_st_mis;
  logic                  w_ld_mis;
  logic                  w_store_ok;
  logic                  w_load_ok;
  logic                  w_unused;

  assign w_l_idx = bus.l_addr[DEPTH_LOG2+1:2];
  assign w_s_idx = bus.s_addr[DEPTH_LOG2+1:2];
  assign w_idle  = (r_state == S_IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_st_mis = (bus.s_addr[1:0] != 2'b00);
  assign w_ld_mis = (bus.l_addr[1:0] != 2'b00);
`else
  assign w_st_mis = 1'b0;
  assign w_ld_mis = 1'b0;
`endif

  // A simultaneous store wins the cycle, so its address is the one checked.
  assign w_store_ok   = w_idle & bus.store_en & ~w_st_mis;
  assign w_load_ok    = w_idle & bus.load_en & ~bus.store_en & ~w_ld_mis;
  assign bus.misalign = w_idle & ((bus.store_en & w_st_mis) |
                                  (bus.load_en & ~bus.store_en & w_ld_mis));

  assign w_unused = ^{bus.l_addr, bus.s_addr};

  always_ff @(posedge clk) begin
    if (w_store_ok) begin
      r_mem[w_s_idx] <= bus.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= '0;
      r_l_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (HAS_LAT && w_load_ok) begin
            r_idx   <= w_l_idx;
            r_cnt   <= CNT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_l_data <= r_mem[r_idx];
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          // Clearing here keeps l_data at 0 outside RESP; held load_en is not re-accepted.
          r_l_data <= '0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall  = HAS_LAT & (w_load_ok | (r_state == S_WAIT));
  assign bus.l_data = HAS_LAT ? r_l_data : (w_load_ok ? r_mem[w_l_idx] : '0);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with LAT=2, LAT=0 and LAT=1.
`timescale 1ns/1ps

module tb_dmem_responder;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  dmem_responder_if #(.W(32)) ifa ();
  dmem_responder_if #(.W(32)) ifb ();
  dmem_responder_if #(.W(32)) ifc ();

  dmem_responder #(.W(32), .DEPTH_LOG2(10), .LAT(2)) u_lat2 (.clk(clk), .rst(rst), .bus(ifa));
  dmem_responder #(.W(32), .DEPTH_LOG2(10), .LAT(0)) u_lat0 (.clk(clk), .rst(rst), .bus(ifb));
  dmem_responder #(.W(32), .DEPTH_LOG2(10), .LAT(1)) u_lat1 (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load on the LAT=2 instance: three stall cycles, then data with stall low, then drop load_en.
  task automatic load_a(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    ifa.load_en = 1'b1;
    ifa.l_addr  = addr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, "_stall"}, {31'd0, ifa.stall}, 32'd1);
      chk({tag, "_ldata_wait"}, ifa.l_data, 32'd0);
      step();
    end
    @(negedge clk);
    chk({tag, "_resp_stall"}, {31'd0, ifa.stall}, 32'd0);
    chk({tag, "_resp_data"}, ifa.l_data, exp);
    step();
    ifa.load_en = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_stall"}, {31'd0, ifa.stall}, 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    ifa.load_en = 0; ifa.l_addr = 0; ifa.store_en = 0; ifa.s_addr = 0; ifa.s_data = 0;
    ifb.load_en = 0; ifb.l_addr = 0; ifb.store_en = 0; ifb.s_addr = 0; ifb.s_data = 0;
    ifc.load_en = 0; ifc.l_addr = 0; ifc.store_en = 0; ifc.s_addr = 0; ifc.s_data = 0;
    rst = 1'b0;
    #3;
    chk("rst_stall", {31'd0, ifa.stall}, 32'd0);
    chk("rst_ldata", ifa.l_data, 32'd0);
    chk("rst_misalign", {31'd0, ifa.misalign}, 32'd0);
    step();
    rst = 1'b1;
    step();

    // LAT=2: store then load, with load_en held through RESP into a back-to-back load
    ifa.store_en = 1; ifa.s_addr = 32'h10; ifa.s_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("l2_store_stall", {31'd0, ifa.stall}, 32'd0);
    step();
    ifa.store_en = 0; ifa.load_en = 1; ifa.l_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("l2_stall", {31'd0, ifa.stall}, 32'd1);
      chk("l2_ldata_wait", ifa.l_data, 32'd0);
      step();
    end
    @(negedge clk);
    chk("l2_resp_stall", {31'd0, ifa.stall}, 32'd0);
    chk("l2_resp_data", ifa.l_data, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("l2_b2b_accept", {31'd0, ifa.stall}, 32'd1);
    chk("l2_b2b_ldata", ifa.l_data, 32'd0);
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("l2_b2b_stall", {31'd0, ifa.stall}, 32'd1);
      step();
    end
    @(negedge clk);
    chk("l2_b2b_data", ifa.l_data, 32'hDEADBEEF);
    chk("l2_b2b_resp_stall", {31'd0, ifa.stall}, 32'd0);
    step();
    ifa.load_en = 0;
    @(negedge clk);
    chk("l2_idle_stall", {31'd0, ifa.stall}, 32'd0);
    chk("l2_idle_ldata", ifa.l_data, 32'd0);
    step();

    // LAT=0: combinational loads, wrap-around, store priority
    ifb.store_en = 1; ifb.s_addr = 32'h40; ifb.s_data = 32'h12345678;
    @(negedge clk);
    chk("l0_store_stall", {31'd0, ifb.stall}, 32'd0);
    step();
    ifb.store_en = 0; ifb.load_en = 1; ifb.l_addr = 32'h40;
    @(negedge clk);
    chk("l0_load_data", ifb.l_data, 32'h12345678);
    chk("l0_load_stall", {31'd0, ifb.stall}, 32'd0);
    step();
    ifb.load_en = 0; ifb.store_en = 1; ifb.s_addr = 32'h1000; ifb.s_data = 32'hA5A5A5A5;
    step();
    ifb.store_en = 0; ifb.load_en = 1; ifb.l_addr = 32'h0;
    @(negedge clk);
    chk("l0_wrap_data", ifb.l_data, 32'hA5A5A5A5);
    step();
    ifb.l_addr = 32'h40; ifb.store_en = 1; ifb.s_addr = 32'h44; ifb.s_data = 32'h00000055;
    @(negedge clk);
    chk("l0_both_ldata", ifb.l_data, 32'd0);
    chk("l0_both_stall", {31'd0, ifb.stall}, 32'd0);
    step();
    ifb.store_en = 0; ifb.l_addr = 32'h44;
    @(negedge clk);
    chk("l0_both_stored", ifb.l_data, 32'h00000055);
    step();
`ifndef DMEM_ALIGN_CHECK_EN
    ifb.l_addr = 32'h42;
    @(negedge clk);
    chk("l0_lowbits_ignored", ifb.l_data, 32'h12345678);
    chk("l0_misalign_tied", {31'd0, ifb.misalign}, 32'd0);
    step();
`endif
    ifb.load_en = 0;

    // LAT=1: held load_en, l_addr and store changes mid-WAIT are ignored
    ifc.store_en = 1; ifc.s_addr = 32'h20; ifc.s_data = 32'h11112222;
    step();
    ifc.s_addr = 32'h24; ifc.s_data = 32'h33334444;
    step();
    ifc.store_en = 0; ifc.load_en = 1; ifc.l_addr = 32'h20;
    @(negedge clk);
    chk("l1_accept_stall", {31'd0, ifc.stall}, 32'd1);
    step();
    ifc.l_addr = 32'h24; ifc.store_en = 1; ifc.s_addr = 32'h20; ifc.s_data = 32'hFFFF0000;
    @(negedge clk);
    chk("l1_wait_stall", {31'd0, ifc.stall}, 32'd1);
    step();
    ifc.store_en = 0;
    @(negedge clk);
    chk("l1_resp_stall", {31'd0, ifc.stall}, 32'd0);
    chk("l1_resp_data", ifc.l_data, 32'h11112222);
    step();
    ifc.load_en = 0;
    @(negedge clk);
    chk("l1_no_reaccept", {31'd0, ifc.stall}, 32'd0);
    step();
    ifc.load_en = 1; ifc.l_addr = 32'h20;
    step();
    step();
    @(negedge clk);
    chk("l1_wait_store_ignored", ifc.l_data, 32'h11112222);
    step();
    ifc.load_en = 0;
    step();

    // Reset mid-WAIT on LAT=2, then a fresh load and a simultaneous load+store
    ifa.load_en = 1; ifa.l_addr = 32'h10;
    step();
    @(negedge clk);
    chk("rstw_pre_stall", {31'd0, ifa.stall}, 32'd1);
    step();
    ifa.load_en = 0;
    rst = 1'b0;
    #1;
    chk("rstw_stall", {31'd0, ifa.stall}, 32'd0);
    chk("rstw_ldata", ifa.l_data, 32'd0);
    step();
    rst = 1'b1;
    step();
    load_a(32'h10, 32'hDEADBEEF, "rstw_fresh");
    ifa.load_en = 1; ifa.l_addr = 32'h10;
    ifa.store_en = 1; ifa.s_addr = 32'h14; ifa.s_data = 32'hCAFEF00D;
    @(negedge clk);
    chk("l2_both_stall", {31'd0, ifa.stall}, 32'd0);
    chk("l2_both_ldata", ifa.l_data, 32'd0);
    step();
    ifa.store_en = 0;
    load_a(32'h14, 32'hCAFEF00D, "l2_both_stored");

`ifdef DMEM_ALIGN_CHECK_EN
    ifa.store_en = 1; ifa.s_addr = 32'h11; ifa.s_data = 32'h00000BAD;
    @(negedge clk);
    chk("al_store_misalign", {31'd0, ifa.misalign}, 32'd1);
    chk("al_store_stall", {31'd0, ifa.stall}, 32'd0);
    step();
    ifa.store_en = 0; ifa.load_en = 1; ifa.l_addr = 32'h12;
    @(negedge clk);
    chk("al_load_misalign", {31'd0, ifa.misalign}, 32'd1);
    chk("al_load_stall", {31'd0, ifa.stall}, 32'd0);
    chk("al_load_ldata", ifa.l_data, 32'd0);
    step();
    ifa.load_en = 0;
    step();
    load_a(32'h10, 32'hDEADBEEF, "al_ram_kept");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
